// File: rtl/button_conditioner_if.sv
// Button bundle between the raw active-low switches and the conditioned outputs.
// The master side drives the raw inputs. The slave (conditioner) side returns level and pulses.
interface button_conditioner_if #(
  parameter int NUM_BTN = 2
);
  logic [NUM_BTN-1:0] btn_n;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  modport master (
    output btn_n,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_n,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchroniser, active-low to active-high inversion, and debounce FSM.
// Each channel produces a stable level plus single-cycle press/release pulses.
module button_conditioner #(
  parameter int NUM_BTN         = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20
) (
  input logic                 clk,
  input logic                 rst,
  button_conditioner_if.slave btn
);

  localparam logic [1:0] ST_RELEASED  = 2'd0;
  localparam logic [1:0] ST_ARMING    = 2'd1;
  localparam logic [1:0] ST_PRESSED   = 2'd2;
  localparam logic [1:0] ST_DISARMING = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] meta_r;
  logic [NUM_BTN-1:0] sync_r;
  logic [NUM_BTN-1:0] level_s;
  logic [NUM_BTN-1:0] press_s;
  logic [NUM_BTN-1:0] rel_s;

  // Two-flop synchroniser on the inverted raw inputs; the only path from btn_n into logic
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= {NUM_BTN{1'b0}};
      sync_r <= {NUM_BTN{1'b0}};
    end else begin
      meta_r <= ~btn.btn_n;
      sync_r <= meta_r;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    logic [1:0]           state_r;
    logic [1:0]           state_nx;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_nx;
    logic                 level_r;
    logic                 level_nx;
    logic                 press_r;
    logic                 press_nx;
    logic                 rel_r;
    logic                 rel_nx;
    logic                 s;

    assign s = sync_r[i];

    // Debounce next-state: the count is compared before incrementing, so it never wraps
    always_comb begin
      state_nx = state_r;
      cnt_nx   = cnt_r;
      level_nx = level_r;
      press_nx = 1'b0;
      rel_nx   = 1'b0;
      case (state_r)
        ST_RELEASED: begin
          if (s) begin
            state_nx = ST_ARMING;
            cnt_nx   = CNT_ZERO;
          end else begin
            state_nx = ST_RELEASED;
          end
        end
        ST_ARMING: begin
          if (!s) begin
            state_nx = ST_RELEASED;
            cnt_nx   = CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_nx = ST_PRESSED;
            level_nx = 1'b1;
            press_nx = 1'b1;
          end else begin
            cnt_nx = cnt_r + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (!s) begin
            state_nx = ST_DISARMING;
            cnt_nx   = CNT_ZERO;
          end else begin
            state_nx = ST_PRESSED;
          end
        end
        ST_DISARMING: begin
          if (s) begin
            state_nx = ST_PRESSED;
            cnt_nx   = CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_nx = ST_RELEASED;
            level_nx = 1'b0;
            rel_nx   = 1'b1;
          end else begin
            cnt_nx = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_nx = ST_RELEASED;
          cnt_nx   = CNT_ZERO;
          level_nx = 1'b0;
        end
      endcase
    end

    // Channel state, counter and registered outputs; reset wins even mid-debounce
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r <= ST_RELEASED;
        cnt_r   <= CNT_ZERO;
        level_r <= 1'b0;
        press_r <= 1'b0;
        rel_r   <= 1'b0;
      end else begin
        state_r <= state_nx;
        cnt_r   <= cnt_nx;
        level_r <= level_nx;
        press_r <= press_nx;
        rel_r   <= rel_nx;
      end
    end

    assign level_s[i] = level_r;
    assign press_s[i] = press_r;
    assign rel_s[i]   = rel_r;
  end

  assign btn.btn_level   = level_s;
  assign btn.btn_press   = press_s;
  assign btn.btn_release = rel_s;

endmodule
